// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM states,
// default sizing and the one-hot helper used for grant/ack vectors.
package shared_reg_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 4;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  // One-hot vector with bit idx set; callers slice down to NUM_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/shared_reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// above the priority pointer, wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_valid
);

  int w_idx;

  // Scan from the farthest offset down so the closest requester to the pointer wins.
  always_comb begin
    w_idx    = 0;
    o_winner = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx    = (int'(i_ptr) + k) % NUM_REQ;
      o_winner = i_req[w_idx[IDX_W-1:0]] ? IDX_W'(w_idx) : o_winner;
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin write arbiter in front of a shared DATA_W-bit register.
// IDLE arbitrates, GRANT captures the winner's data (or aborts if its request
// dropped), ACK pulses the write-complete strobe for one cycle.
// Optional macro SHARED_REG_WCOUNT_EN adds a saturating 8-bit completed-write
// counter on output wr_count.
module shared_reg_write_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           data_out,
  output logic                        busy,
`ifdef SHARED_REG_WCOUNT_EN
  output logic [7:0]                  wr_count,
`endif
  output logic [$clog2(NUM_REQ)-1:0]  last_owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;
  logic [IDX_W-1:0]    r_owner, w_owner_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]    r_winner, w_winner_nxt;
  logic                w_write;

  logic [IDX_W-1:0]    w_pick;
  logic                w_pick_valid;
  logic [MAX_REQ-1:0]  w_oh_pick_full, w_oh_win_full;
  logic [NUM_REQ-1:0]  w_oh_pick, w_oh_win;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  assign w_oh_pick_full = onehot(3'(w_pick));
  assign w_oh_win_full  = onehot(3'(r_winner));
  assign w_oh_pick      = w_oh_pick_full[NUM_REQ-1:0];
  assign w_oh_win       = w_oh_win_full[NUM_REQ-1:0];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-value logic for every registered output and the pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_ack_nxt    = {NUM_REQ{1'b0}};
    w_data_nxt   = r_data;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_winner_nxt = r_winner;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt    = w_oh_pick;
          w_winner_nxt = w_pick;
          w_state_nxt  = GRANT;
        end else begin
          w_gnt_nxt    = {NUM_REQ{1'b0}};
        end
      end
      GRANT: begin
        w_gnt_nxt = {NUM_REQ{1'b0}};
        if (req[r_winner]) begin
          // Data is sampled only here; the pointer moves past the winner.
          w_data_nxt  = wr_data[int'(r_winner)*DATA_W +: DATA_W];
          w_ack_nxt   = w_oh_win;
          w_owner_nxt = r_winner;
          w_ptr_nxt   = (r_winner == LAST_IDX) ? {IDX_W{1'b0}} : r_winner + IDX_W'(1);
          w_write     = 1'b1;
          w_state_nxt = ACK;
        end else begin
          // Requester withdrew: no write, pointer keeps its position.
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // Datapath and output registers; reset clears any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= {NUM_REQ{1'b0}};
      r_ack    <= {NUM_REQ{1'b0}};
      r_data   <= {DATA_W{1'b0}};
      r_owner  <= {IDX_W{1'b0}};
      r_ptr    <= {IDX_W{1'b0}};
      r_winner <= {IDX_W{1'b0}};
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_ack    <= w_ack_nxt;
      r_data   <= w_data_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_winner <= w_winner_nxt;
    end
  end

`ifdef SHARED_REG_WCOUNT_EN
  logic [7:0] r_wcount;

  // Count completed writes, holding at 255 instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcount <= 8'd0;
    end else if (w_write && (r_wcount != 8'd255)) begin
      r_wcount <= r_wcount + 8'd1;
    end
  end

  assign wr_count = r_wcount;
`endif

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign data_out   = r_data;
  assign last_owner = r_owner;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Self-checking bench for shared_reg_write_arbiter (NUM_REQ=4, DATA_W=4).
// A transaction-level model predicts outputs every cycle; directed sections
// pin the model with hand-computed values.
module tb_shared_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] wr_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  data_out;
  logic        busy;
  logic [1:0]  last_owner;
`ifdef SHARED_REG_WCOUNT_EN
  logic [7:0]  wr_count;
`endif

  shared_reg_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr_data    (wr_data),
    .gnt        (gnt),
    .ack        (ack),
    .data_out   (data_out),
    .busy       (busy),
`ifdef SHARED_REG_WCOUNT_EN
    .wr_count   (wr_count),
`endif
    .last_owner (last_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no transaction, 1 = winner holds grant, 2 = write just completed
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_win   = 0;
  int         m_owner = 0;
  int         m_wcount = 0;
  logic [3:0] m_gnt  = 4'd0;
  logic [3:0] m_ack  = 4'd0;
  logic [3:0] m_data = 4'd0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (((r >> ((p + k) % N)) & 4'd1) != 4'd0) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_owner = 0; m_wcount = 0;
      m_gnt = 4'd0; m_ack = 4'd0; m_data = 4'd0;
    end else begin
      m_ack = 4'd0;
      if (m_phase == 0) begin
        if (req != 4'd0) begin
          m_win   = first_from(req, m_ptr);
          m_gnt   = 4'(1 << m_win);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_gnt = 4'd0;
        if (((req >> m_win) & 4'd1) != 4'd0) begin
          m_data   = 4'(wr_data >> (W * m_win));
          m_ack    = 4'(1 << m_win);
          m_owner  = m_win;
          m_ptr    = (m_win + 1) % N;
          m_wcount = (m_wcount < 255) ? m_wcount + 1 : 255;
          m_phase  = 2;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk("m_gnt",   32'(gnt),        32'(m_gnt));
    chk("m_ack",   32'(ack),        32'(m_ack));
    chk("m_data",  32'(data_out),   32'(m_data));
    chk("m_busy",  32'(busy),       32'(m_phase != 0));
    chk("m_owner", 32'(last_owner), 32'(m_owner));
    chk("gnt_ack_excl", 32'((gnt != 4'd0) && (ack != 4'd0)), 32'd0);
`ifdef SHARED_REG_WCOUNT_EN
    chk("m_wcount", 32'(wr_count), 32'(m_wcount));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  int   exp_idx [5] = '{0, 1, 2, 3, 0};
  int   exp_dat [5] = '{1, 2, 3, 4, 1};
  int   ack_cyc [5];
  logic ok;

  initial begin
    rst = 1'b1; req = 4'd0; wr_data = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   32'(gnt),        32'd0);
    chk("rst_ack",   32'(ack),        32'd0);
    chk("rst_data",  32'(data_out),   32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_owner", 32'(last_owner), 32'd0);
    tick(); rst = 1'b0;

    // Reset while in GRANT: nothing written, no ack ever.
    req = 4'b0001; wr_data = 16'h000A;
    tick(); chk("rg_gnt", 32'(gnt), 32'd1);
    rst = 1'b1; #1;
    chk("rg_gnt0",  32'(gnt),      32'd0);
    chk("rg_ack0",  32'(ack),      32'd0);
    chk("rg_data0", 32'(data_out), 32'd0);
    chk("rg_busy0", 32'(busy),     32'd0);
    tick(); req = 4'd0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rg_no_ack", 32'(ack), 32'd0);
    end

    // Reset while in ACK: data_out returns to 0 immediately.
    req = 4'b0001; wr_data = 16'h000A;
    tick(); tick();
    chk("ra_ack",  32'(ack),      32'd1);
    chk("ra_data", 32'(data_out), 32'd10);
    rst = 1'b1; #1;
    chk("ra_data0", 32'(data_out), 32'd0);
    chk("ra_ack0",  32'(ack),      32'd0);
    tick(); req = 4'd0; rst = 1'b0;

    // Abort with pointer at 0, then 0011 goes to requester 0.
    req = 4'b0010; wr_data = 16'h0021;
    tick(); chk("ab_gnt", 32'(gnt), 32'd2);
    req = 4'd0;
    tick();
    chk("ab_gnt0", 32'(gnt),      32'd0);
    chk("ab_ack0", 32'(ack),      32'd0);
    chk("ab_data", 32'(data_out), 32'd0);
    chk("ab_busy", 32'(busy),     32'd0);
    req = 4'b0011;
    tick(); chk("ab_next_gnt", 32'(gnt), 32'd1);
    tick();
    chk("ab_next_ack",  32'(ack),      32'd1);
    chk("ab_next_data", 32'(data_out), 32'd1);
    req = 4'd0;
    tick(); chk("ab_idle", 32'(busy), 32'd0);

    // Fairness from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; wr_data = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      wait_ack("fair_timeout", ok);
      ack_cyc[i] = cyc;
      chk("fair_ack",  32'(ack),      32'(1 << exp_idx[i]));
      chk("fair_data", 32'(data_out), 32'(exp_dat[i]));
      if (i > 0) chk("fair_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    req = 4'd0;
    tick();

    // Single write to requester 2 (pointer now 1); late data change ignored.
    req = 4'b0100; wr_data = 16'h0500;
    tick();
    chk("sw_gnt",  32'(gnt),  32'd4);
    chk("sw_busy", 32'(busy), 32'd1);
    tick();
    chk("sw_data",  32'(data_out),   32'd5);
    chk("sw_ack",   32'(ack),        32'd4);
    chk("sw_owner", 32'(last_owner), 32'd2);
    chk("sw_gnt0",  32'(gnt),        32'd0);
    req = 4'd0; wr_data = 16'h0F00;
    tick();
    chk("sw_ack0",  32'(ack),      32'd0);
    chk("sw_hold",  32'(data_out), 32'd5);

    // Wrap: pointer 3, requester 3 beats 0, then 0 goes next.
    req = 4'b1001; wr_data = 16'h9007;
    wait_ack("wrap_timeout", ok);
    chk("wrap_ack3",  32'(ack),      32'd8);
    chk("wrap_data3", 32'(data_out), 32'd9);
    req = 4'b0001;
    wait_ack("wrap_timeout", ok);
    chk("wrap_ack0",  32'(ack),        32'd1);
    chk("wrap_data0", 32'(data_out),   32'd7);
    chk("wrap_own0",  32'(last_owner), 32'd0);
    req = 4'd0;
    tick();

`ifdef SHARED_REG_WCOUNT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; wr_data = 16'h0003;
    for (int i = 0; i < 300; i++) wait_ack("wc_timeout", ok);
    req = 4'd0;
    tick();
    chk("wc_sat", 32'(wr_count), 32'd255);
    req = 4'b0010;
    tick(); req = 4'd0;
    tick(); tick();
    chk("wc_abort", 32'(wr_count), 32'd255);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_write_arbiter.md
Name: shared_reg_write_arbiter

Overview:
- Round-robin arbiter and sequencer that lets NUM_REQ requesters share one DATA_W-bit data register.
- Grants one requester at a time, captures its write data into the shared register, and returns a one-cycle ack.
- Sits in front of the 4-bit register datapath as the single point of write access.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, width of the shared register and of each requester's write data.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; level, held until ack.
- wr_data  input  NUM_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, registered.
- ack  output  NUM_REQ  one-hot write-complete pulse, registered.
- data_out  output  DATA_W  shared register contents.
- busy  output  1  high whenever state is not IDLE.
- last_owner  output  $clog2(NUM_REQ)  index of the requester that performed the most recent completed write.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, gnt=0, ack=0, data_out=0, last_owner=0.
  - Priority pointer=0, so requester 0 has highest priority first.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If req!=0 at a rising edge: winner = first set bit of req searching upward from the pointer, wrapping at NUM_REQ-1 -> 0.
  - On that edge: gnt<=onehot(winner), winner index latched, state<=GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - If req[winner]=1 at the edge: data_out<=wr_data[winner slice], ack<=onehot(winner), gnt<=0, last_owner<=winner, pointer<=(winner+1) mod NUM_REQ, state<=ACK.
  - If req[winner]=0 (abort): gnt<=0, no write, no ack, pointer unchanged, state<=IDLE.
- ACK: next edge ack<=0, state<=IDLE.
- Timing:
  - Latency from req sampled high to data_out updated is 2 edges.
  - ack is high exactly one cycle, coincident with the new data_out.
  - Maximum throughput is one write per 3 cycles.
- Other requesters' req bits are ignored outside IDLE arbitration; they hold and wait.
- wr_data is sampled only at the GRANT edge; changes at any other time have no effect.
- gnt and ack are never both nonzero; at most one bit of each is set.
- Single requester held high continuously: it is granted every 3 cycles.
- All requesters held high: grants go 0,1,2,3,0,... (fair rotation).
- Pointer wrap: a winner of NUM_REQ-1 sets the pointer to 0.
- Reset asserted mid-operation (GRANT or ACK): all state clears immediately, no partial write, and data_out returns to 0.

Optional Feature:
- Macro: SHARED_REG_WCOUNT_EN.
- Defined:
  - Adds output wr_count [7:0], reset to 0.
  - Increments on every completed write (the GRANT->ACK transition), saturating at 255.
  - Aborts do not count.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package shared_reg_arb_pkg:
  - State enum {IDLE, GRANT, ACK}.
  - Defaults NUM_REQ_DEF=4, DATA_W_DEF=4.
  - Function onehot(idx).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, pointer.
  - Outputs: winner index and a valid flag.
  - Instantiated once.

Test Plan:
- Reset: assert rst mid-GRANT with req=4'b0001, wr_data[3:0]=4'd10 -> gnt, ack and data_out go 0 immediately; no ack ever seen for that request.
- Single write: req=4'b0100, slice2=4'd5 -> gnt=4'b0100 after edge 1; data_out=5, ack=4'b0100, last_owner=2 after edge 2; ack low after edge 3.
- Fairness: req=4'b1111 held with slices 1,2,3,4 -> acks in order 0,1,2,3,0; data_out sequence 1,2,3,4,1, one every 3 cycles.
- Wrap: pointer=3 after owner 2, req=4'b1001 -> requester 3 granted before 0; the next grant goes to 0.
- Abort: req=4'b0010 granted, then req dropped before the GRANT edge -> no ack, data_out unchanged, the next grant with req=4'b0011 goes to requester 0.
- With SHARED_REG_WCOUNT_EN defined: 300 back-to-back writes -> wr_count=255; one abort -> wr_count unchanged.
